// File: rtl/arm_instr_encoder.sv
// Packs structured operation requests into 32-bit ARM instruction words and streams them
// with sequential word addresses. Define ARM_ENCODER_CHECK_EN to reject illegal requests via err.
module arm_instr_encoder #(
    parameter int ADDR_W     = 8,
    parameter int BASE_ADDR  = 0,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        kind,
    input  logic [3:0]        cond,
    input  logic [3:0]        cmd,
    input  logic              s,
    input  logic              link,
    input  logic [3:0]        rn,
    input  logic [3:0]        rd,
    input  logic [3:0]        rm,
    input  logic [3:0]        rs,
    input  logic [3:0]        rot,
    input  logic [7:0]        imm8,
    input  logic [4:0]        shamt,
    input  logic [1:0]        sh,
    input  logic [23:0]       offset,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              wrapped,
    output logic              err
);

    localparam int                PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]    DEPTH = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);

    // Compare class always sets flags and discards Rd; MOV/MVN ignore Rn.
    function automatic logic [31:0] encode(
        input logic [1:0]  k,
        input logic [3:0]  c,
        input logic [3:0]  op,
        input logic        set_f,
        input logic        lnk,
        input logic [3:0]  n,
        input logic [3:0]  d,
        input logic [3:0]  m,
        input logic [3:0]  sreg,
        input logic [3:0]  r,
        input logic [7:0]  imm,
        input logic [4:0]  amt,
        input logic [1:0]  styp,
        input logic [23:0] ofs
    );
        logic       cmp_cls;
        logic       mov_cls;
        logic       s_eff;
        logic [3:0] rd_eff;
        logic [3:0] rn_eff;
        cmp_cls = (op[3:2] == 2'b10);
        mov_cls = op[3] & op[2] & op[0];
        s_eff   = cmp_cls ? 1'b1 : set_f;
        rd_eff  = cmp_cls ? 4'd0 : d;
        rn_eff  = mov_cls ? 4'd0 : n;
        unique case (k)
            2'b00:   encode = {c, 2'b00, 1'b1, op, s_eff, rn_eff, rd_eff, r, imm};
            2'b01:   encode = {c, 2'b00, 1'b0, op, s_eff, rn_eff, rd_eff, amt, styp, 1'b0, m};
            2'b10:   encode = {c, 3'b101, lnk, ofs};
            default: encode = {c, 6'b000000, 1'b0, set_f, d, 4'b0000, sreg, 4'b1001, m};
        endcase
    endfunction

`ifdef ARM_ENCODER_CHECK_EN
    function automatic logic illegal_req(
        input logic [1:0] k,
        input logic       set_f,
        input logic [3:0] d,
        input logic [3:0] m
    );
        if (k == 2'b11)
            illegal_req = (d == 4'd15) || (d == m) || (m == 4'd15);
        else if (k[1] == 1'b0)
            illegal_req = (d == 4'd15) && set_f;
        else
            illegal_req = 1'b0;
    endfunction
`endif

    logic [31:0]       fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wrapped_q, wrapped_d;
    logic              full;
    logic              accept;
    logic              push;
    logic              pop;
    logic              illegal;
    logic [31:0]       enc_word;

    assign full      = (count_q == DEPTH);
    assign out_valid = (count_q != '0);
    assign in_ready  = !full || (out_valid && out_ready);
    assign accept    = in_valid && in_ready && !start;
    assign push      = accept && !illegal;
    assign pop       = out_valid && out_ready && !start;

    assign enc_word = encode(kind, cond, cmd, s, link, rn, rd, rm, rs, rot, imm8, shamt, sh, offset);

    // Addresses are bound at emission: the head address advances only on an output handshake.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        addr_d    = addr_q;
        wrapped_d = wrapped_q;
        if (start) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            addr_d    = BASE;
            wrapped_d = 1'b0;
        end else begin
            if (push)
                wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                addr_d   = addr_q + 1'b1;
                if (addr_q == '1)
                    wrapped_d = 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            addr_q    <= BASE;
            wrapped_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            addr_q    <= addr_d;
            wrapped_q <= wrapped_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_q[wr_ptr_q] <= enc_word;
    end

    // Storage is not reset, so the word is masked while the buffer is empty.
    assign out_instr = out_valid ? fifo_q[rd_ptr_q] : 32'h0;
    assign out_addr  = addr_q;
    assign wrapped   = wrapped_q;

`ifdef ARM_ENCODER_CHECK_EN
    logic err_q, err_d;

    assign illegal = illegal_req(kind, s, rd, rm);
    assign err_d   = accept && illegal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err_q <= 1'b0;
        else
            err_q <= err_d;
    end

    assign err = err_q;
`else
    assign illegal = 1'b0;
    assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_arm_instr_encoder.sv
// Randomized bench for arm_instr_encoder with a queue-based reference model and
// hand-computed literal checks for the encodings, backpressure, wrap, start and async reset.
module tb_arm_instr_encoder;

    localparam int ADDR_W     = 2;
    localparam int BASE_ADDR  = 0;
    localparam int FIFO_DEPTH = 2;
    localparam int NADDR      = 1 << ADDR_W;
`ifdef ARM_ENCODER_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    typedef struct packed {
        logic [1:0]  kind;
        logic [3:0]  cond;
        logic [3:0]  cmd;
        logic        s;
        logic        link;
        logic [3:0]  rn;
        logic [3:0]  rd;
        logic [3:0]  rm;
        logic [3:0]  rs;
        logic [3:0]  rot;
        logic [7:0]  imm8;
        logic [4:0]  shamt;
        logic [1:0]  sh;
        logic [23:0] offset;
    } req_t;

    logic              clk       = 1'b0;
    logic              reset     = 1'b0;
    logic              start     = 1'b0;
    logic              in_valid  = 1'b0;
    logic              out_ready = 1'b0;
    req_t              cur       = '0;
    logic              in_ready;
    logic              out_valid;
    logic              wrapped;
    logic              err;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    arm_instr_encoder #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .kind     (cur.kind),
        .cond     (cur.cond),
        .cmd      (cur.cmd),
        .s        (cur.s),
        .link     (cur.link),
        .rn       (cur.rn),
        .rd       (cur.rd),
        .rm       (cur.rm),
        .rs       (cur.rs),
        .rot      (cur.rot),
        .imm8     (cur.imm8),
        .shamt    (cur.shamt),
        .sh       (cur.sh),
        .offset   (cur.offset),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instr(out_instr),
        .out_addr (out_addr),
        .wrapped  (wrapped),
        .err      (err)
    );

    // Reference encoding built from shifted field values.
    function automatic logic [31:0] m_encode(req_t r);
        logic [31:0] c;
        logic [31:0] s_eff;
        logic [31:0] rd_eff;
        logic [31:0] rn_eff;
        logic [31:0] w;
        c      = 32'(r.cond) << 28;
        s_eff  = 32'(r.s);
        rd_eff = 32'(r.rd);
        rn_eff = 32'(r.rn);
        if (r.cmd >= 4'd8 && r.cmd <= 4'd11) begin
            s_eff  = 32'd1;
            rd_eff = 32'd0;
        end
        if (r.cmd == 4'd13 || r.cmd == 4'd15)
            rn_eff = 32'd0;
        case (r.kind)
            2'd0: w = c | (32'd1 << 25) | (32'(r.cmd) << 21) | (s_eff << 20) | (rn_eff << 16)
                      | (rd_eff << 12) | (32'(r.rot) << 8) | 32'(r.imm8);
            2'd1: w = c | (32'(r.cmd) << 21) | (s_eff << 20) | (rn_eff << 16) | (rd_eff << 12)
                      | (32'(r.shamt) << 7) | (32'(r.sh) << 5) | 32'(r.rm);
            2'd2: w = c | (32'd5 << 25) | (32'(r.link) << 24) | 32'(r.offset);
            default: w = c | (32'(r.s) << 20) | (32'(r.rd) << 16) | (32'(r.rs) << 8)
                         | (32'd9 << 4) | 32'(r.rm);
        endcase
        return w;
    endfunction

    function automatic bit m_illegal(req_t r);
        bit bad;
        if (r.kind == 2'd3)
            bad = (r.rd == 4'd15) || (r.rd == r.rm) || (r.rm == 4'd15);
        else if (r.kind == 2'd2)
            bad = 1'b0;
        else
            bad = (r.rd == 4'd15) && r.s;
        return CHECK_EN && bad;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        r.kind   = 2'($urandom);
        r.cond   = 4'($urandom);
        r.cmd    = 4'($urandom);
        r.s      = 1'($urandom);
        r.link   = 1'($urandom);
        r.rn     = 4'($urandom);
        r.rd     = 4'($urandom);
        r.rm     = 4'($urandom);
        r.rs     = 4'($urandom);
        r.rot    = 4'($urandom);
        r.imm8   = 8'($urandom);
        r.shamt  = 5'($urandom);
        r.sh     = 2'($urandom);
        r.offset = 24'($urandom);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, got, want, $time);
        end
    endtask

    // Reference model state: expected FIFO contents in order, head address, flags.
    logic [31:0] mq[$];
    int          m_addr    = BASE_ADDR;
    bit          m_wrapped = 1'b0;
    bit          m_err     = 1'b0;
    bit          mon_en    = 1'b0;
    bit          p_acc     = 1'b0;
    bit          p_pop     = 1'b0;
    bit          p_start   = 1'b0;
    bit          p_ill     = 1'b0;
    logic [31:0] p_word    = '0;

    // Compare process: outputs checked every negedge, then handshakes decided from the model.
    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            bit          ev;
            bit          er;
            logic [31:0] wi;
            ev = (mq.size() > 0);
            wi = 32'h0;
            if (ev)
                wi = mq[0];
            er = (mq.size() < FIFO_DEPTH) || (ev && out_ready);
            chk("out_valid", 32'(out_valid), 32'(ev));
            chk("out_instr", out_instr, wi);
            chk("out_addr", 32'(out_addr), 32'(m_addr));
            chk("wrapped", 32'(wrapped), 32'(m_wrapped));
            chk("err", 32'(err), 32'(m_err));
            chk("in_ready", 32'(in_ready), 32'(er));
            p_start = start;
            p_acc   = in_valid && er && !start;
            p_pop   = ev && out_ready && !start;
            p_ill   = m_illegal(cur);
            p_word  = m_encode(cur);
        end
    end

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            mq.delete();
            m_addr    = BASE_ADDR;
            m_wrapped = 1'b0;
            m_err     = 1'b0;
            p_acc     = 1'b0;
            p_pop     = 1'b0;
            p_start   = 1'b0;
        end else if (mon_en) begin
            if (p_start) begin
                mq.delete();
                m_addr    = BASE_ADDR;
                m_wrapped = 1'b0;
                m_err     = 1'b0;
            end else begin
                if (p_pop) begin
                    void'(mq.pop_front());
                    if (m_addr == NADDR - 1)
                        m_wrapped = 1'b1;
                    m_addr = (m_addr + 1) % NADDR;
                end
                if (p_acc && !p_ill)
                    mq.push_back(p_word);
                m_err = p_acc && p_ill;
            end
            p_acc   = 1'b0;
            p_pop   = 1'b0;
            p_start = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one request into an empty buffer with out_ready=1 and pin the emitted word.
    task automatic send(input req_t r, input logic [31:0] want_instr, input int want_addr,
                        input string name);
        cur      = r;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_instr"}, out_instr, want_instr);
        chk({name, "_addr"}, 32'(out_addr), 32'(want_addr));
        tick();
    endtask

    task automatic offer(input req_t r);
        cur      = r;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pulse_start(input string name);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({name, "_valid"}, 32'(out_valid), 32'd0);
        chk({name, "_addr"}, 32'(out_addr), 32'(BASE_ADDR));
        chk({name, "_wrapped"}, 32'(wrapped), 32'd0);
    endtask

    function automatic req_t br(input logic [23:0] ofs);
        req_t r;
        r        = '0;
        r.kind   = 2'd2;
        r.cond   = 4'hE;
        r.offset = ofs;
        return r;
    endfunction

    initial begin
        req_t r;
        #1 reset = 1'b1;
        #1 mon_en = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_out_addr", 32'(out_addr), 32'(BASE_ADDR));
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        tick();
        reset = 1'b0;
        tick();

        r = '0; r.kind = 2'd0; r.cond = 4'hE; r.cmd = 4'h4; r.rn = 4'd1; r.rd = 4'd2; r.imm8 = 8'd5;
        send(r, 32'hE2812005, 0, "add_imm");
        r = '0; r.kind = 2'd1; r.cond = 4'hE; r.cmd = 4'hA; r.rd = 4'd7; r.rn = 4'd3; r.rm = 4'd4;
        send(r, 32'hE1530004, 1, "cmp_reg");
        send(br(24'hFFFFFE), 32'hEAFFFFFE, 2, "branch");
        r = br(24'hFFFFFE); r.link = 1'b1;
        send(r, 32'hEBFFFFFE, 3, "branch_link");
        chk("wrap_after_4th", 32'(wrapped), 32'd1);
        r = '0; r.kind = 2'd3; r.cond = 4'hE; r.s = 1'b1; r.rd = 4'd0; r.rs = 4'd2; r.rm = 4'd1;
        send(r, 32'hE0100291, 0, "mul");
`ifdef ARM_ENCODER_CHECK_EN
        r.rd = 4'd1;
        offer(r);
        @(negedge clk);
        chk("illegal_err", 32'(err), 32'd1);
        chk("illegal_no_out", 32'(out_valid), 32'd0);
        tick();
        chk("illegal_err_pulse", 32'(err), 32'd0);
`endif
        pulse_start("start1");

        // Backpressure: two words fill the buffer, the third waits for a drain slot.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cur      = br(24'(i));
            in_valid = 1'b1;
            tick();
        end
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_head", out_instr, 32'hEA000000);
        repeat (3) tick();
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_w0", out_instr, 32'hEA000000);
        chk("bp_a0", 32'(out_addr), 32'd0);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_w1", out_instr, 32'hEA000001);
        chk("bp_a1", 32'(out_addr), 32'd1);
        tick();
        @(negedge clk);
        chk("bp_w2", out_instr, 32'hEA000002);
        chk("bp_a2", 32'(out_addr), 32'd2);
        tick();

        pulse_start("start2");
        for (int i = 0; i < 5; i++) begin
            send(br(24'(16 + i)), 32'hEA000010 + 32'(i), i % NADDR, "wrap");
            chk("wrap_flag", 32'(wrapped), 32'(i >= 3));
        end
        pulse_start("start3");

        // Asynchronous reset with two words buffered and a non-base head address.
        send(br(24'h000100), 32'hEA000100, 0, "pre_rst");
        out_ready = 1'b0;
        offer(br(24'h000200));
        offer(br(24'h000300));
        chk("pre_rst_full", 32'(in_ready), 32'd0);
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_addr", 32'(out_addr), 32'(BASE_ADDR));
        tick();
        reset     = 1'b0;
        out_ready = 1'b1;
        tick();

        for (int n = 0; n < 800; n++) begin
            cur       = rand_req();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            start     = ($urandom_range(0, 39) == 0);
            tick();
        end
        in_valid  = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arm_instr_encoder.md
Name: arm_instr_encoder

Overview:
- Packs structured operation requests into 32-bit ARM instruction words and streams them, with sequential word addresses, toward instruction memory or a program loader.
- It is the encoding counterpart of the CPU's instruction/ALU decode path.
- Used by the bench/bootstrap infrastructure to build programs that the core's decoder must consume bit-exactly.
- Sits between a request source (valid/ready) and an imem write port (valid/ready).

Parameters:
ADDR_W, 8, width of the word-address counter.
BASE_ADDR, 0, word address loaded on reset and on start.
FIFO_DEPTH, 2, output buffer entries; power of two, at least 2.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
start  in  1  synchronous restart: address := BASE_ADDR, clears wrapped, flushes FIFO.
in_valid  in  1  request valid.
in_ready  out  1  request accepted when in_valid && in_ready.
kind  in  2  00 DP-immediate, 01 DP-register, 10 branch, 11 multiply.
cond  in  4  condition field.
cmd  in  4  DP opcode.
s  in  1  set-flags.
link  in  1  branch-with-link.
rn  in  4  first operand register.
rd  in  4  destination register.
rm  in  4  second operand register.
rs  in  4  multiply operand register.
rot  in  4  immediate rotate.
imm8  in  8  immediate.
shamt  in  5  shift amount.
sh  in  2  shift type.
offset  in  24  branch word offset.
out_valid  out  1  word available.
out_ready  in  1  consumer accepts.
out_instr  out  32  encoded word.
out_addr  out  ADDR_W  word address of out_instr.
wrapped  out  1  sticky; set when the address counter wraps.
err  out  1  illegal-request pulse; see Optional Feature.

Behaviour:
- Reset (async): FIFO empty, out_valid=0, out_instr=0, out_addr=BASE_ADDR, wrapped=0, err=0, in_ready=1.
- in_ready = !fifo_full || (out_valid && out_ready). The FIFO accepts and drains in the same cycle when full.
- Latency: a request accepted at edge N is visible on out_instr/out_valid after edge N (registered). There is no combinational path from in_* to out_*.
- Output order matches acceptance order.
- Encoding:
  - DP-imm = {cond, 2'b00, 1, cmd, s', rn, rd', rot, imm8}.
  - DP-reg = {cond, 2'b00, 0, cmd, s', rn, rd', shamt, sh, 0, rm}.
  - Branch = {cond, 3'b101, link, offset}.
  - Multiply = {cond, 6'b000000, 0, s, rd, 4'b0000, rs, 4'b1001, rm}.
- Compare class (cmd 1000..1011): s' = 1 and rd' = 0 regardless of inputs. Otherwise s' = s and rd' = rd.
- MOV/MVN class (cmd 1101, 1111): rn forced to 0.
- Address counter: each out handshake (out_valid && out_ready) increments the head address.
- Addresses are assigned at emission time, not at acceptance: out_addr is the current head address.
- Wrap: at 2^ADDR_W-1 the counter increments to 0 and wrapped is set. It stays set until reset or start.
- start:
  - Takes priority over a simultaneous in/out handshake; both are ignored that cycle.
  - out_valid=0 the next cycle.
  - in_ready may be 1 during start, but no request is captured.
- out_valid held with out_ready=0: out_instr and out_addr must remain stable.

Optional Feature:
- Macro: ARM_ENCODER_CHECK_EN.
- Defined: the following requests are illegal:
  - kind 11 with rd==15, rd==rm, or rm==15.
  - kind 00/01 with rd==15 and s==1.
- An illegal request is accepted (in_ready honoured) but not written to the FIFO.
- err pulses high for exactly one cycle after acceptance. The address counter is unaffected.
- Undefined: err is tied 0 and every request is encoded as given.

Test Plan:
- ADD imm: cond=1110, cmd=0100, s=0, rn=1, rd=2, rot=0, imm8=5 -> out_instr=0xE2812005, out_addr=0, one cycle after acceptance.
- CMP reg: cmd=1010, s=0, rd=7, rn=3, rm=4, shamt=0, sh=00 -> 0xE1530004 (S forced, Rd zeroed). Branch: cond=1110, link=0, offset=0xFFFFFE -> 0xEAFFFFFE; with link=1 -> 0xEBFFFFFE.
- MUL: s=1, rd=0, rs=2, rm=1 -> 0xE0100291. With ARM_ENCODER_CHECK_EN, rd=1, rm=1 -> no output, err=1 for one cycle.
- Backpressure: out_ready=0 while 3 requests are offered -> 2 accepted, in_ready=0. Then out_ready=1 -> words drained in order at addresses 0,1, then 2, with stable data while stalled.
- Wrap/start: ADDR_W=2, emit 5 words -> addresses 0,1,2,3,0 and wrapped=1 after the 4th. Pulse start -> out_addr=BASE_ADDR, wrapped=0, FIFO empty.
- Assert reset mid-stream with 2 words buffered -> out_valid=0, out_addr=BASE_ADDR immediately, without waiting for a clock edge.
